// File: rtl/encoder_4to2_stream_pkg.sv
// encoder_pkg: shared types and the one-hot encode rule for the 4-to-2 stream encoder
package encoder_pkg;

   typedef logic [3:0] onehot_t;
   typedef logic [1:0] enc_code_t;

   typedef struct packed {
      enc_code_t code;
      logic      err;
   } enc_entry_t;

   typedef enum logic [1:0] {EMPTY, ONE, FULL} occ_state_t;

   // Highest set bit wins; err flags anything that is not exactly one bit set
   function automatic enc_entry_t encode_onehot(input onehot_t w);
      enc_entry_t e;
      e.code = w[3] ? 2'd3 : w[2] ? 2'd2 : w[1] ? 2'd1 : 2'd0;
      e.err  = (w == 4'd0) || ((w & (w - 4'd1)) != 4'd0);
      return e;
   endfunction

endpackage

// File: rtl/enc_pipe_fifo.sv
// enc_pipe_fifo: 2-entry FIFO of encoded entries driven by an EMPTY/ONE/FULL occupancy FSM
module enc_pipe_fifo
   import encoder_pkg::*;
(
   input  logic       clk,
   input  logic       rst_n,
   input  logic       push_i,
   input  enc_entry_t data_i,
   input  logic       out_ready_i,
   output logic       valid_o,
   output logic       ready_o,
   output enc_entry_t data_o
);

   occ_state_t state_q, state_d;
   enc_entry_t head_q, head_d;
   enc_entry_t tail_q, tail_d;
   logic       pop;

   assign valid_o = (state_q != EMPTY);
   assign ready_o = (state_q != FULL);
   assign pop     = valid_o && out_ready_i;
   assign data_o  = head_q;

   // State and storage registers; reset empties the buffer and clears both slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= EMPTY;
         head_q  <= '0;
         tail_q  <= '0;
      end else begin
         state_q <= state_d;
         head_q  <= head_d;
         tail_q  <= tail_d;
      end
   end

   // Occupancy transitions; a push+pop at ONE replaces the head in place
   always_comb begin
      state_d = state_q;
      head_d  = head_q;
      tail_d  = tail_q;
      case (state_q)
         EMPTY: begin
            if (push_i) begin
               state_d = ONE;
               head_d  = data_i;
            end
         end
         ONE: begin
            if (push_i && pop) begin
               head_d = data_i;
            end else if (push_i) begin
               state_d = FULL;
               tail_d  = data_i;
            end else if (pop) begin
               state_d = EMPTY;
            end
         end
         FULL: begin
            if (pop) begin
               state_d = ONE;
               head_d  = tail_q;
            end
         end
         default: state_d = EMPTY;
      endcase
   end

endmodule

// File: rtl/encoder_4to2_stream.sv
// encoder_4to2_stream: handshaked 4-to-2 priority encoder with error flag and saturating error count
module encoder_4to2_stream
   import encoder_pkg::*;
#(
   parameter int CNT_W = 8
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [3:0]       en_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [1:0]       en_out,
   output logic             out_err,
   output logic [CNT_W-1:0] err_cnt
);

   enc_entry_t       din;
   enc_entry_t       head;
   logic             push;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   assign din     = encode_onehot(en_in);
   assign push    = in_valid && in_ready;
   assign en_out  = head.code;
   assign out_err = head.err;
   assign err_cnt = cnt_q;

   enc_pipe_fifo u_fifo (
      .clk         (clk),
      .rst_n       (rst_n),
      .push_i      (push),
      .data_i      (din),
      .out_ready_i (out_ready),
      .valid_o     (out_valid),
      .ready_o     (in_ready),
      .data_o      (head)
   );

   // Error counter next state: count erroneous pushes, hold at all-ones
   always_comb begin
      cnt_d = (push && din.err && (cnt_q != '1)) ? cnt_q + CNT_W'(1) : cnt_q;
   end

   // Error counter register
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) cnt_q <= '0;
      else        cnt_q <= cnt_d;
   end

endmodule

// File: doc/encoder_4to2_stream.md
# encoder_4to2_stream

Streaming 4-to-2 priority encoder: the inverse of the 2-to-4 decoder. It accepts 4-bit one-hot words over a valid/ready handshake and returns the 2-bit binary index, with a per-word error flag for non-one-hot inputs. A 2-entry output buffer decouples producer and consumer, and a saturating counter tracks malformed inputs. It sits between a one-hot request source and any index-consuming logic.

## Interface
- `CNT_W`, default 8: width of the error counter.
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_valid`  in  1  `en_in` holds a word.
- `in_ready`  out  1  block can accept a word this cycle.
- `en_in`  in  4  one-hot input word.
- `out_valid`  out  1  `en_out`/`out_err` hold a result.
- `out_ready`  in  1  consumer accepts the result this cycle.
- `en_out`  out  2  encoded index.
- `out_err`  out  1  accompanying input was not exactly one-hot.
- `err_cnt`  out  CNT_W  saturating count of accepted words with error.

## Operation
- Push when `in_valid && in_ready`. Pop when `out_valid && out_ready`.
- Encode rule (priority, highest bit wins):
  - 1xxx→3, 01xx→2, 001x→1, 0001→0, 0000→0.
  - `err` = (popcount(`en_in`) != 1).
- Each pushed word stores {code, err} in a 2-entry FIFO (3 bits per entry). The head is presented on `en_out`/`out_err`.
- Occupancy FSM states: EMPTY, ONE, FULL.
  - EMPTY: push→ONE.
  - ONE: push only→FULL; pop only→EMPTY; push+pop→ONE, head replaced by new word.
  - FULL: pop→ONE; push is impossible.
- Outputs are registered functions of state:
  - `out_valid` = (state != EMPTY).
  - `in_ready` = (state != FULL).
  - There is no combinational path from `out_ready` to `in_ready`.
- `err_cnt` increments by 1 on each push with err=1 and saturates at 2^CNT_W−1. It never wraps.
- `en_in` is ignored when no push occurs.
- Holding rules:
  - `en_out`/`out_err` hold stable while `out_valid && !out_ready`.
  - Producer data is don't-care when `in_valid` is low.
- Reset (asynchronous, any time, including mid-transfer):
  - state=EMPTY, `out_valid`=0, `in_ready`=1, `en_out`=0, `out_err`=0, `err_cnt`=0, storage cleared.
  - Words in flight are discarded.
  - The first push is accepted on the first rising edge after `rst_n` deasserts.

## Timing
- Latency: a word pushed at edge N appears on `out_valid`/`en_out` after edge N (one cycle). If older entries are queued, it appears later, in FIFO order.
- Throughput: one word per cycle sustained when `out_ready` is held high. The state stays ONE with simultaneous push+pop.
- Backpressure:
  - With `out_ready`=0, two words are accepted.
  - `in_ready` drops after the edge that fills the FIFO.
  - `in_ready` returns high the cycle after the first pop.
- `err_cnt` updates at the same edge as the push that carries the error.

## Structure
- Package `encoder_pkg`:
  - `onehot_t` (logic [3:0]).
  - `enc_code_t` (logic [1:0]).
  - `enc_entry_t` packed struct {code, err}.
  - `occ_state_t` enum {EMPTY, ONE, FULL}.
  - Function `encode_onehot()` returning `enc_entry_t`.
- Sub-module `enc_pipe_fifo`: the 2-entry FIFO plus occupancy FSM, generic over the `enc_entry_t` payload.
- Top level: instantiates the encode function, `enc_pipe_fifo` and the error counter.

## Test plan
- Reset, then push 0001, 0010, 0100, 1000 back-to-back with `out_ready`=1.
  - Outputs 0,1,2,3 on consecutive cycles with `out_err`=0.
  - `in_ready` stays 1 throughout.
- Push 0000, 0110, 1111.
  - Codes 0,2,3, all with `out_err`=1.
  - `err_cnt`=3.
- Backpressure: `out_ready`=0, offer 0010, 1000, 0001.
  - First two accepted; `in_ready`=0 on the third.
  - Raise `out_ready`: pops 1 then 3, then 0001 is accepted and output as 0.
- `CNT_W`=2, push 5 error words: `err_cnt` reads 1,2,3,3,3 (saturated).
- Assert `rst_n`=0 while FULL with `err_cnt`=2.
  - Outputs immediately become `out_valid`=0, `in_ready`=1, `err_cnt`=0, `en_out`=0.
  - The next push after release produces the correct code.
- Random valid/ready toggling for 10k cycles.
  - Scoreboard order matches the encode rule.
  - No loss or duplication.
  - Output is stable while stalled.
